gate_response_checker: RTL and testbench

- Sequential self-checking harness block for the gate-implementation equivalence flow.
- Drives every input combination into NUM_DUT parallel gate implementations (gate-level, behavioural, data-flow).
- Samples their outputs after a settle window and compares each against an internal golden NAND (~&vec).
- Reports pass/fail, a saturating mismatch count and the first failing vector. This is the checking end of the stimulus/monitor flow, usable in synthesisable self-test.

---
 rtl/gate_response_checker.sv | 141 ++++++++++++++
 tb/tb_gate_response_checker.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/gate_response_checker.sv
// gate_response_checker: drives every IN_W-bit vector into NUM_DUT parallel gate
// implementations, samples their outputs after a settle window and compares each
// against a golden NAND, reporting pass/fail, a saturating mismatch count and the
// first failing vector.
//
// Ports:
//   clk             rising-edge clock for all state
//   rst_n           synchronous active-low reset
//   start           one-cycle run request, honoured only in IDLE or DONE
//   dut_out         bit i = output of DUT i for the currently driven vector
//   vec             stimulus vector driven to all DUTs
//   busy            high while a run is in progress
//   done            high once a run has finished, held until the next start
//   pass            valid while done=1; 1 iff err_count==0
//   err_count       saturating count of (vector, DUT) mismatches
//   first_fail_vec  vector of the first mismatching sample, 0 if none
//   first_fail_mask per-DUT mismatch bits at the first failing vector, 0 if none
module gate_response_checker #(
    parameter int IN_W    = 2,
    parameter int NUM_DUT = 3,
    parameter int SETTLE  = 1,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [NUM_DUT-1:0] dut_out,
    output logic [IN_W-1:0]    vec,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [CNT_W-1:0]   err_count,
    output logic [IN_W-1:0]    first_fail_vec,
    output logic [NUM_DUT-1:0] first_fail_mask
);
    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    localparam int PW = $clog2(NUM_DUT + 1);
    localparam int SW = CNT_W + PW;
    localparam logic [3:0] RELOAD = 4'(SETTLE - 1);
    localparam logic [SW-1:0] MAXV = {{PW{1'b0}}, {CNT_W{1'b1}}};

    state_t state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [IN_W-1:0] vec_n, ffv_n;
    logic [NUM_DUT-1:0] ffm_n, mismatch;
    logic [CNT_W-1:0] err_n, err_sat;
    logic [PW-1:0] pop;
    logic [SW-1:0] sum;
    logic busy_n, done_n, pass_n, seen, seen_n;

    // Golden NAND replicated across all DUT lanes; a set bit is a failing lane.
    always_comb begin
        mismatch = dut_out ^ {NUM_DUT{~&vec}};
        pop = '0;
        for (int i = 0; i < NUM_DUT; i++)
            pop = pop + PW'(mismatch[i]);
        sum = {{PW{1'b0}}, err_count} + SW'(pop);
        err_sat = (sum > MAXV) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        vec_n   = vec;
        busy_n  = busy;
        done_n  = done;
        pass_n  = pass;
        err_n   = err_count;
        ffv_n   = first_fail_vec;
        ffm_n   = first_fail_mask;
        seen_n  = seen;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n = DRIVE;
                    cnt_n   = RELOAD;
                    vec_n   = '0;
                    busy_n  = 1'b1;
                    done_n  = 1'b0;
                    pass_n  = 1'b0;
                    err_n   = '0;
                    ffv_n   = '0;
                    ffm_n   = '0;
                    seen_n  = 1'b0;
                end
            end
            DRIVE: begin
                state_n = (cnt == 4'd0) ? SAMPLE : DRIVE;
                cnt_n   = (cnt == 4'd0) ? cnt : cnt - 4'd1;
            end
            SAMPLE: begin
                err_n = err_sat;
                // The first-fail record keys off its own flag so counter
                // saturation can never mask or overwrite it.
                if (|mismatch && !seen) begin
                    ffv_n  = vec;
                    ffm_n  = mismatch;
                    seen_n = 1'b1;
                end
                if (&vec) begin
                    state_n = DONE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    pass_n  = (err_sat == '0);
                end else begin
                    state_n = DRIVE;
                    vec_n   = vec + 1'b1;
                    cnt_n   = RELOAD;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            cnt             <= '0;
            vec             <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_fail_vec  <= '0;
            first_fail_mask <= '0;
            seen            <= 1'b0;
        end else begin
            state           <= state_n;
            cnt             <= cnt_n;
            vec             <= vec_n;
            busy            <= busy_n;
            done            <= done_n;
            pass            <= pass_n;
            err_count       <= err_n;
            first_fail_vec  <= ffv_n;
            first_fail_mask <= ffm_n;
            seen            <= seen_n;
        end
    end
endmodule

// File: tb/tb_gate_response_checker.sv
// tb_gate_response_checker: table-driven and directed checks of gate_response_checker
// using three instances (defaults, SETTLE=3, CNT_W=2) fed by a behavioural DUT model.
module tb_gate_response_checker;
    logic clk = 1'b0;
    logic rst_n;
    logic [2:0] start;
    logic [5:0] mode;
    logic [2:0] dout [3];
    logic [1:0] vec_o [3];
    logic [1:0] ffv_o [3];
    logic [2:0] ffm_o [3];
    logic busy_o [3];
    logic done_o [3];
    logic pass_o [3];
    logic [7:0] err_a, err_b;
    logic [1:0] err_c;
    logic [7:0] err_o [3];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    // Per-DUT behaviour (2 bits each): 0 correct NAND, 1 stuck-at-0, 2 stuck-at-1, 3 AND
    function automatic logic [2:0] model(input logic [5:0] m, input logic [1:0] v);
        logic n;
        logic [2:0] r;
        n = ~&v;
        for (int i = 0; i < 3; i++)
            r[i] = (m[2*i+:2] == 2'd0) ? n : (m[2*i+:2] == 2'd1) ? 1'b0 :
                   (m[2*i+:2] == 2'd2) ? 1'b1 : ~n;
        return r;
    endfunction

    always_comb
        for (int i = 0; i < 3; i++)
            dout[i] = model(mode, vec_o[i]);

    assign err_o[0] = err_a;
    assign err_o[1] = err_b;
    assign err_o[2] = {6'd0, err_c};

    gate_response_checker u_a (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .dut_out(dout[0]), .vec(vec_o[0]),
        .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]), .err_count(err_a),
        .first_fail_vec(ffv_o[0]), .first_fail_mask(ffm_o[0]));

    gate_response_checker #(.SETTLE(3)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .dut_out(dout[1]), .vec(vec_o[1]),
        .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]), .err_count(err_b),
        .first_fail_vec(ffv_o[1]), .first_fail_mask(ffm_o[1]));

    gate_response_checker #(.CNT_W(2)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .dut_out(dout[2]), .vec(vec_o[2]),
        .busy(busy_o[2]), .done(done_o[2]), .pass(pass_o[2]), .err_count(err_c),
        .first_fail_vec(ffv_o[2]), .first_fail_mask(ffm_o[2]));

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Runs instance i to completion; optionally pulses start again at run cycle restart_at.
    task automatic run(input int i, input logic [5:0] m, input int settle, input int restart_at,
                       input int e_err, input int e_ffv, input int e_ffm, input int e_pass);
        int cyc;
        mode = m;
        @(negedge clk) start[i] = 1'b1;
        @(negedge clk) start[i] = 1'b0;
        chk("accept_busy", int'(busy_o[i]), 1);
        chk("accept_done", int'(done_o[i]), 0);
        chk("accept_err", int'(err_o[i]), 0);
        chk("accept_ffv", int'(ffv_o[i]), 0);
        chk("accept_ffm", int'(ffm_o[i]), 0);
        cyc = 0;
        while (!done_o[i] && cyc < 200) begin
            chk("run_vec", int'(vec_o[i]), cyc / (settle + 1));
            start[i] = (cyc == restart_at);
            @(negedge clk);
            cyc++;
        end
        start[i] = 1'b0;
        chk("latency", cyc, 4 * (settle + 1));
        chk("end_busy", int'(busy_o[i]), 0);
        chk("end_vec", int'(vec_o[i]), 3);
        chk("err_count", int'(err_o[i]), e_err);
        chk("first_fail_vec", int'(ffv_o[i]), e_ffv);
        chk("first_fail_mask", int'(ffm_o[i]), e_ffm);
        chk("pass", int'(pass_o[i]), e_pass);
        repeat (2) @(negedge clk);
        chk("done_held", int'(done_o[i]), 1);
    endtask

    typedef struct {
        logic [5:0] m;
        int err;
        int ffv;
        int ffm;
        int ps;
    } vec_t;

    vec_t tbl [7];

    initial begin
        tbl[0] = '{6'b000000, 0, 0, 3'b000, 1};
        tbl[1] = '{6'b000100, 3, 0, 3'b010, 0};
        tbl[2] = '{6'b110000, 4, 0, 3'b100, 0};
        tbl[3] = '{6'b000000, 0, 0, 3'b000, 1};
        tbl[4] = '{6'b101010, 3, 3, 3'b111, 0};
        tbl[5] = '{6'b111111, 12, 0, 3'b111, 0};
        tbl[6] = '{6'b000110, 4, 0, 3'b010, 0};

        start = '0;
        mode = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_vec", int'(vec_o[0]), 0);
        chk("rst_busy", int'(busy_o[0]), 0);
        chk("rst_done", int'(done_o[0]), 0);
        chk("rst_pass", int'(pass_o[0]), 0);
        chk("rst_err", int'(err_o[0]), 0);
        chk("rst_ffv", int'(ffv_o[0]), 0);
        chk("rst_ffm", int'(ffm_o[0]), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 7; k++)
            run(0, tbl[k].m, 1, -1, tbl[k].err, tbl[k].ffv, tbl[k].ffm, tbl[k].ps);

        // SETTLE=3 with a stray start at cycle 5 that must be ignored
        run(1, 6'b000000, 3, 5, 0, 0, 0, 1);

        // CNT_W=2: exact fill, then saturation without disturbing the first-fail record
        run(2, 6'b101010, 1, -1, 3, 3, 3'b111, 0);
        run(2, 6'b111111, 1, -1, 3, 0, 3'b111, 0);

        // Reset during SAMPLE of vec=2, with start held high under reset
        mode = 6'b111111;
        @(negedge clk) start[0] = 1'b1;
        @(negedge clk) start[0] = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_vec", int'(vec_o[0]), 2);
        chk("mid_err", int'(err_o[0]), 6);
        rst_n = 1'b0;
        start[0] = 1'b1;
        @(negedge clk);
        chk("abort_vec", int'(vec_o[0]), 0);
        chk("abort_busy", int'(busy_o[0]), 0);
        chk("abort_done", int'(done_o[0]), 0);
        chk("abort_err", int'(err_o[0]), 0);
        chk("abort_ffm", int'(ffm_o[0]), 0);
        rst_n = 1'b1;
        start[0] = 1'b0;
        @(negedge clk);
        chk("no_accept_busy", int'(busy_o[0]), 0);
        chk("no_accept_done", int'(done_o[0]), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
